// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter on a JK cell bank; q updates one clk after load/count, tc and j_o/k_o are combinational.
// No backpressure: load/en are accepted every cycle, and rst wins over load, which wins over en.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             load_err,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o
);

    // One extra bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);

    logic             q_in_range;
    logic             ld_clamp;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] j_exc;
    logic [WIDTH-1:0] k_exc;

    assign q_in_range = ({1'b0, q} < MOD_EXT);
    assign ld_clamp   = !({1'b0, load_val} < MOD_EXT);
    assign ld_val     = ld_clamp ? LAST : load_val;

    // An out-of-range state (upset) recovers to 0 on the next count step.
    always_comb begin
        count_nxt = '0;
        if (q_in_range) begin
            if (up) begin
                count_nxt = (q == LAST) ? '0 : q + 1'b1;
            end else begin
                count_nxt = (q == '0) ? LAST : q - 1'b1;
            end
        end
    end

    always_comb begin
        j_exc = '0;
        k_exc = '0;
        if (load) begin
            j_exc = ld_val;
            k_exc = ~ld_val;
        end else if (en) begin
            j_exc = q ^ count_nxt;
            k_exc = q ^ count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j_exc[i], k_exc[i]})
                    2'b01:   q[i] <= 1'b0;
                    2'b10:   q[i] <= 1'b1;
                    2'b11:   q[i] <= ~q[i];
                    default: q[i] <= q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load & ld_clamp;
        end
    end

    assign tc  = en & ~load & ((up & (q == LAST)) | (~up & (q == '0)));
    assign j_o = j_exc;
    assign k_o = k_exc;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed vectors for jk_mod_counter (WIDTH=4, MODULUS=10) checked through a scoreboard queue.
module tb_jk_mod_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc;
    logic       load_err;
    logic [3:0] j_o;
    logic [3:0] k_o;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
        .load_err (load_err),
        .j_o      (j_o),
        .k_o      (k_o)
    );

    typedef struct {
        int         idx;
        logic [3:0] q;
        logic       lerr;
        logic       tc;
        logic [3:0] j;
        logic [3:0] k;
        bit         chk_jk;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   row_idx  = 0;
    bit   done     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
    endtask

    // Each negedge shows q/load_err from the last edge plus comb outputs for the current inputs.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q", e.idx, q, e.q);
                chk("load_err", e.idx, {3'b0, load_err}, {3'b0, e.lerr});
                chk("tc", e.idx, {3'b0, tc}, {3'b0, e.tc});
                if (e.chk_jk) begin
                    chk("j_o", e.idx, j_o, e.j);
                    chk("k_o", e.idx, k_o, e.k);
                end
            end
        end
    end

    // Inputs are applied just after a posedge; the expectation covers the following negedge.
    task automatic row(input logic r, input logic e_, input logic u, input logic l, input logic [3:0] lv,
                       input logic [3:0] eq, input logic elerr, input logic etc,
                       input logic [3:0] ej, input logic [3:0] ek, input bit cjk);
        exp_t x;
        rst = r; en = e_; up = u; load = l; load_val = lv;
        x.idx = row_idx; x.q = eq; x.lerr = elerr; x.tc = etc;
        x.j = ej; x.k = ek; x.chk_jk = cjk;
        sb.push_back(x);
        row_idx++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;
        rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd7;
        @(posedge clk);
        #1;
        //   rst en up ld lv      q     lerr tc  j        k        chk
        row(1, 1, 1, 1, 4'd7,   4'd0, 0, 0, 4'b0000, 4'b0000, 0);
        row(0, 1, 1, 0, 4'd0,   4'd0, 0, 0, 4'b0001, 4'b0001, 1);
        row(0, 1, 1, 0, 4'd0,   4'd1, 0, 0, 4'b0011, 4'b0011, 1);
        row(0, 1, 1, 0, 4'd0,   4'd2, 0, 0, 4'b0001, 4'b0001, 1);
        row(0, 1, 1, 0, 4'd0,   4'd3, 0, 0, 4'b0111, 4'b0111, 1);
        row(0, 1, 1, 0, 4'd0,   4'd4, 0, 0, 4'b0001, 4'b0001, 1);
        row(0, 1, 1, 0, 4'd0,   4'd5, 0, 0, 4'b0011, 4'b0011, 1);
        row(0, 1, 1, 0, 4'd0,   4'd6, 0, 0, 4'b0001, 4'b0001, 1);
        row(0, 1, 1, 0, 4'd0,   4'd7, 0, 0, 4'b1111, 4'b1111, 1);
        row(0, 1, 1, 0, 4'd0,   4'd8, 0, 0, 4'b0001, 4'b0001, 1);
        row(0, 1, 1, 0, 4'd0,   4'd9, 0, 1, 4'b1001, 4'b1001, 1);
        row(0, 1, 1, 0, 4'd0,   4'd0, 0, 0, 4'b0001, 4'b0001, 1);
        row(0, 1, 1, 0, 4'd0,   4'd1, 0, 0, 4'b0011, 4'b0011, 1);
        row(0, 1, 1, 0, 4'd0,   4'd2, 0, 0, 4'b0001, 4'b0001, 1);
        // load collides with count: 13 clamps to 9, then a legal load of 5
        row(0, 1, 1, 1, 4'd13,  4'd3, 0, 0, 4'b1001, 4'b0110, 1);
        row(0, 1, 1, 1, 4'd5,   4'd9, 1, 0, 4'b0101, 4'b1010, 1);
        row(0, 0, 1, 0, 4'd0,   4'd5, 0, 0, 4'b0000, 4'b0000, 1);
        row(0, 0, 1, 1, 4'd7,   4'd5, 0, 0, 4'b0111, 4'b1000, 1);
        // hold at 7 while up toggles
        row(0, 0, 1, 0, 4'd0,   4'd7, 0, 0, 4'b0000, 4'b0000, 1);
        row(0, 0, 0, 0, 4'd0,   4'd7, 0, 0, 4'b0000, 4'b0000, 1);
        row(0, 0, 1, 0, 4'd0,   4'd7, 0, 0, 4'b0000, 4'b0000, 1);
        row(0, 0, 0, 0, 4'd0,   4'd7, 0, 0, 4'b0000, 4'b0000, 1);
        row(0, 0, 1, 0, 4'd0,   4'd7, 0, 0, 4'b0000, 4'b0000, 1);
        // load boundaries: 9 is legal, 10 clamps to 9
        row(0, 0, 1, 1, 4'd9,   4'd7, 0, 0, 4'b1001, 4'b0110, 1);
        row(0, 0, 1, 1, 4'd10,  4'd9, 0, 0, 4'b1001, 4'b0110, 1);
        row(0, 0, 1, 1, 4'd1,   4'd9, 1, 0, 4'b0001, 4'b1110, 1);
        row(0, 0, 1, 0, 4'd0,   4'd1, 0, 0, 4'b0000, 4'b0000, 1);
        // count down through the wrap
        row(0, 1, 0, 0, 4'd0,   4'd1, 0, 0, 4'b0001, 4'b0001, 1);
        row(0, 1, 0, 0, 4'd0,   4'd0, 0, 1, 4'b1001, 4'b1001, 1);
        row(0, 1, 0, 0, 4'd0,   4'd9, 0, 0, 4'b0001, 4'b0001, 1);
        row(0, 1, 0, 0, 4'd0,   4'd8, 0, 0, 4'b1111, 4'b1111, 1);
        row(0, 1, 0, 0, 4'd0,   4'd7, 0, 0, 4'b0001, 4'b0001, 1);
        // reset mid-count, then resume
        row(1, 1, 1, 0, 4'd0,   4'd6, 0, 0, 4'b0000, 4'b0000, 0);
        row(0, 1, 1, 0, 4'd0,   4'd0, 0, 0, 4'b0001, 4'b0001, 1);
        row(0, 0, 1, 0, 4'd0,   4'd1, 0, 0, 4'b0000, 4'b0000, 1);

        waited = 0;
        while (sb.size() > 0 && waited < 5) begin
            @(posedge clk);
            waited++;
        end
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());
        done = 1;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
